// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
// Player-input, coin and DIP-switch front end between hps_io and a game core.
// Joystick bits are synchronised and debounced on the game clock-enable,
// packed into cabinet bytes, coin presses become fixed-length pulses with
// hold lockout, and DIP bytes are captured from ioctl index 254.

module arcade_input_mapper #(
  parameter int PLAYERS    = 4,
  parameter int DIP_BYTES  = 2,
  parameter int DEBOUNCE   = 4,
  parameter int COIN_PULSE = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic [PLAYERS*16-1:0]  joystick,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [PLAYERS*8-1:0]   player,
  output logic [PLAYERS-1:0]     coin,
  output logic                   service,
  output logic [DIP_BYTES*8-1:0] dsw,
  output logic                   dip_valid
);

  // Nine meaningful bits per player: 0 right .. 8 service
  localparam int         NBITS   = PLAYERS * 9;
  localparam logic       OUT_INV = 1'(ACTIVE_LOW);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [7:0] CP_LOAD = 8'(COIN_PULSE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_LOCK  = 2'd2
  } coin_state_t;

  logic [NBITS-1:0]     raw_s;
  logic                 joy_unused_s;
  logic [NBITS-1:0]     sync1_r;
  logic [NBITS-1:0]     sync2_r;
  logic [NBITS-1:0]     acc_r;
  logic [3:0]           db_cnt_r [NBITS];
  logic [PLAYERS*8-1:0] player_s;
  logic                 service_s;
  logic [PLAYERS-1:0]   coin_acc_s;
  logic [PLAYERS-1:0]   coin_prev_r;
  coin_state_t          coin_state_r [PLAYERS];
  logic [7:0]           coin_cnt_r [PLAYERS];
  logic                 dip_hit_s;
  logic [DIP_BYTES-1:0] dip_flags_r;
  logic [DIP_BYTES-1:0] dip_flags_next_s;

  // Gather the nine used bits of each joystick word; bits 9..15 are folded away
  always_comb begin
    raw_s        = '0;
    joy_unused_s = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_s[p*9 +: 9] = joystick[p*16 +: 9];
      joy_unused_s    = joy_unused_s ^ (^joystick[p*16+9 +: 7]);
    end
  end

  // Two-flop synchroniser for every used input bit
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debouncer: a change is accepted after DEBOUNCE consecutive ce ticks
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt_r[i] <= 4'd0;
      end
    end else if (ce) begin
      for (int i = 0; i < NBITS; i++) begin
        if (sync2_r[i] == acc_r[i]) begin
          db_cnt_r[i] <= 4'd0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          acc_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= 4'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 4'd1;
        end
      end
    end
  end

  // Pack accepted bits into {start, 0, B, A, left, right, down, up} and OR service
  always_comb begin
    player_s   = '0;
    service_s  = 1'b0;
    coin_acc_s = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      player_s[p*8 +: 8] = {acc_r[p*9+6], 1'b0, acc_r[p*9+5], acc_r[p*9+4],
                            acc_r[p*9+1], acc_r[p*9+0], acc_r[p*9+2], acc_r[p*9+3]};
      service_s          = service_s | acc_r[p*9+8];
      coin_acc_s[p]      = acc_r[p*9+7];
    end
  end

  // Registered game-facing player bytes and service, inverted for active-low cabinets
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      player  <= {(PLAYERS*8){OUT_INV}};
      service <= OUT_INV;
    end else begin
      player  <= player_s ^ {(PLAYERS*8){OUT_INV}};
      service <= service_s ^ OUT_INV;
    end
  end

  // Coin FSMs: one fixed-length pulse per accepted press, locked out while held
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin        <= {PLAYERS{OUT_INV}};
      coin_prev_r <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_state_r[p] <= ST_IDLE;
        coin_cnt_r[p]   <= 8'd0;
      end
    end else begin
      coin_prev_r <= coin_acc_s;
      for (int p = 0; p < PLAYERS; p++) begin
        case (coin_state_r[p])
          ST_IDLE: begin
            if (coin_acc_s[p] && !coin_prev_r[p]) begin
              coin_state_r[p] <= ST_PULSE;
              coin_cnt_r[p]   <= CP_LOAD;
              coin[p]         <= ~OUT_INV;
            end
          end
          ST_PULSE: begin
            if (ce) begin
              if (coin_cnt_r[p] == 8'd1) begin
                coin_cnt_r[p]   <= 8'd0;
                coin[p]         <= OUT_INV;
                coin_state_r[p] <= coin_acc_s[p] ? ST_LOCK : ST_IDLE;
              end else begin
                coin_cnt_r[p] <= coin_cnt_r[p] - 8'd1;
              end
            end
          end
          ST_LOCK: begin
            if (!coin_acc_s[p]) begin
              coin_state_r[p] <= ST_IDLE;
            end
          end
          default: begin
            coin_state_r[p] <= ST_IDLE;
            coin_cnt_r[p]   <= 8'd0;
            coin[p]         <= OUT_INV;
          end
        endcase
      end
    end
  end

  // A qualifying DIP write: index 254, low byte addresses below DIP_BYTES only
  always_comb begin
    dip_hit_s = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0) &&
                ({1'b0, ioctl_addr[2:0]} < 4'(DIP_BYTES));
  end

  // Next written-flag vector so dip_valid can rise with the last byte
  always_comb begin
    dip_flags_next_s = dip_flags_r;
    for (int k = 0; k < DIP_BYTES; k++) begin
      if (dip_hit_s && (ioctl_addr[2:0] == 3'(k))) begin
        dip_flags_next_s[k] = 1'b1;
      end else begin
        dip_flags_next_s[k] = dip_flags_r[k];
      end
    end
  end

  // DIP byte capture with sticky written flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dsw         <= {(DIP_BYTES*8){1'b1}};
      dip_flags_r <= '0;
      dip_valid   <= 1'b0;
    end else begin
      dip_flags_r <= dip_flags_next_s;
      dip_valid   <= &dip_flags_next_s;
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (dip_hit_s && (ioctl_addr[2:0] == 3'(k))) begin
          dsw[k*8 +: 8] <= ioctl_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: a 4-player active-low instance and a
// 1-player active-high instance, table vectors plus coin/reset sequences.

module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [63:0] joy_a;
  logic [15:0] joy_b;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [31:0] player_a;
  logic [3:0]  coin_a;
  logic        service_a;
  logic [15:0] dsw_a;
  logic        dip_valid_a;
  logic [7:0]  player_b;
  logic [0:0]  coin_b;
  logic        service_b;
  logic [15:0] dsw_b;
  logic        dip_valid_b;

  int total = 0;
  int bad   = 0;

  arcade_input_mapper #(
    .PLAYERS(4), .DIP_BYTES(2), .DEBOUNCE(4), .COIN_PULSE(16), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .joystick(joy_a),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .player(player_a), .coin(coin_a),
    .service(service_a), .dsw(dsw_a), .dip_valid(dip_valid_a)
  );

  arcade_input_mapper #(
    .PLAYERS(1), .DIP_BYTES(2), .DEBOUNCE(4), .COIN_PULSE(16), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .joystick(joy_b),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .player(player_b), .coin(coin_b),
    .service(service_b), .dsw(dsw_b), .dip_valid(dip_valid_b)
  );

  always #5 clk_sys = ~clk_sys;

  // ce is high one clock in three, changed shortly after each rising edge
  initial begin
    int ce_div;
    ce_div = 0;
    ce     = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      ce_div = (ce_div == 2) ? 0 : ce_div + 1;
      ce     = (ce_div == 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watch coin[0] of dut_a: count pulse starts and ce ticks spent asserted (active low)
  task automatic measure_coin(input int clocks, output int pulses, output int width);
    logic act;
    logic prev;
    pulses = 0;
    width  = 0;
    prev   = 1'b0;
    for (int c = 0; c < clocks; c++) begin
      @(negedge clk_sys);
      act = (coin_a[0] == 1'b0);
      if (act && !prev) pulses++;
      if (act && ce) width++;
      prev = act;
    end
  endtask

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [15:0] exp_dsw;
    logic        exp_valid;
  } dip_vec_t;

  typedef struct {
    logic [15:0] joy;
    logic [7:0]  exp_player;
    logic        exp_service;
  } joy_vec_t;

  dip_vec_t dv [6];
  joy_vec_t jv [9];

  initial begin
    int  pulses;
    int  width;
    int  ticks;
    int  waited;
    logic changed;

    dv[0] = '{8'd254, 25'd0, 8'h3C, 16'hFF3C, 1'b0};
    dv[1] = '{8'd254, 25'd5, 8'h00, 16'hFF3C, 1'b0};  // beyond DIP_BYTES
    dv[2] = '{8'd253, 25'd1, 8'h11, 16'hFF3C, 1'b0};  // wrong index
    dv[3] = '{8'd254, 25'd9, 8'h22, 16'hFF3C, 1'b0};  // upper address bits set
    dv[4] = '{8'd254, 25'd1, 8'hA5, 16'hA53C, 1'b1};
    dv[5] = '{8'd254, 25'd0, 8'h77, 16'hA577, 1'b1};  // rewrite keeps valid

    // player byte is {start, 0, B, A, left, right, down, up}
    jv[0] = '{16'h0141, 8'h84, 1'b1};  // right + start + service
    jv[1] = '{16'h0008, 8'h01, 1'b0};  // up
    jv[2] = '{16'h0004, 8'h02, 1'b0};  // down
    jv[3] = '{16'h0002, 8'h08, 1'b0};  // left
    jv[4] = '{16'h0010, 8'h10, 1'b0};  // A
    jv[5] = '{16'h0020, 8'h20, 1'b0};  // B
    jv[6] = '{16'h0080, 8'h00, 1'b0};  // coin is not in the byte
    jv[7] = '{16'h01FF, 8'hBF, 1'b1};  // all bits, bit 6 stays 0
    jv[8] = '{16'h0000, 8'h00, 1'b0};

    reset_n     = 1'b0;
    joy_a       = '0;
    joy_b       = '0;
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'd0;

    repeat (3) @(negedge clk_sys);
    check("rst_player_a", player_a, 64'hFFFF_FFFF);
    check("rst_coin_a", coin_a, 64'hF);
    check("rst_service_a", service_a, 64'h1);
    check("rst_dsw_a", dsw_a, 64'hFFFF);
    check("rst_dip_valid_a", dip_valid_a, 64'h0);
    check("rst_player_b", player_b, 64'h0);
    check("rst_coin_b", coin_b, 64'h0);
    check("rst_service_b", service_b, 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // DIP capture table
    for (int i = 0; i < 6; i++) begin
      ioctl_wr    = 1'b1;
      ioctl_index = dv[i].idx;
      ioctl_addr  = dv[i].addr;
      ioctl_dout  = dv[i].dout;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check($sformatf("dip_dsw_%0d", i), dsw_a, dv[i].exp_dsw);
      check($sformatf("dip_valid_%0d", i), dip_valid_a, dv[i].exp_valid);
      @(negedge clk_sys);
    end

    // P2 A glitch of 3 ce ticks must not reach the output
    changed   = 1'b0;
    joy_a[20] = 1'b1;
    repeat (9) @(negedge clk_sys);
    joy_a[20] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_sys);
      if (player_a[15:8] !== 8'hFF) changed = 1'b1;
    end
    check("glitch_3ce_p2", changed, 64'h0);

    // P2 A held for 4+ ce ticks is accepted
    joy_a[20] = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("hold_4ce_p2", player_a[15:8], 64'hEF);
    joy_a[20] = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("release_p2", player_a[15:8], 64'hFF);

    // P1 coin held for 100 ce ticks: exactly one 16-tick pulse
    joy_a[7] = 1'b1;
    measure_coin(300, pulses, width);
    check("coin_hold_pulses", pulses, 64'd1);
    check("coin_hold_width", width, 64'd16);
    check("coin_hold_idle", coin_a, 64'hF);
    joy_a[7] = 1'b0;
    measure_coin(60, pulses, width);
    check("coin_release_pulses", pulses, 64'd0);
    joy_a[7] = 1'b1;
    measure_coin(120, pulses, width);
    check("coin_repress_pulses", pulses, 64'd1);
    check("coin_repress_width", width, 64'd16);

    // Fresh pulse, then reset at its 8th ce tick
    joy_a[7] = 1'b0;
    repeat (40) @(negedge clk_sys);
    joy_a[7] = 1'b1;
    waited   = 0;
    while (coin_a[0] !== 1'b0 && waited < 80) begin
      @(negedge clk_sys);
      waited++;
    end
    check("coin_start_seen", (waited < 80), 64'h1);
    ticks  = 0;
    waited = 0;
    while (ticks < 8 && waited < 60) begin
      if (ce) ticks++;
      if (ticks < 8) @(negedge clk_sys);
      waited++;
    end
    check("coin_mid_active", coin_a[0], 64'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_coin", coin_a, 64'hF);
    check("abort_player", player_a, 64'hFFFF_FFFF);
    check("abort_dsw", dsw_a, 64'hFFFF);
    check("abort_dip_valid", dip_valid_a, 64'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    measure_coin(120, pulses, width);
    check("post_rst_pulses", pulses, 64'd1);
    check("post_rst_width", width, 64'd16);
    joy_a[7] = 1'b0;

    // Single-player active-high mapping table
    for (int i = 0; i < 9; i++) begin
      joy_b = jv[i].joy;
      repeat (24) @(negedge clk_sys);
      check($sformatf("map_player_%0d", i), player_b, jv[i].exp_player);
      check($sformatf("map_service_%0d", i), service_b, jv[i].exp_service);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
